// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    // Multi-cycle execute tracking states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

    // Integer register x0 is hard-wired to zero and never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a source operand is read by the ID instruction and names rd.
    function automatic logic src_hit(
        input logic       used,
        input logic [4:0] rs,
        input logic [4:0] rd
    );
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Performance counters for the hazard unit: load-use bubbles and
// multi-cycle stall cycles. Both wrap and clear on synchronous reset.
module hazard_perf_counters
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN_CNT = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                lu_event_i,
    input  logic                mc_event_i,
    output logic [XLEN_CNT-1:0] load_use_cnt_o,
    output logic [XLEN_CNT-1:0] mc_stall_cnt_o
);

    logic [XLEN_CNT-1:0] lu_cnt_q, lu_cnt_d;
    logic [XLEN_CNT-1:0] mc_cnt_q, mc_cnt_d;

    // Next-count computation; natural wrap on overflow.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        mc_cnt_d = mc_cnt_q;
        if (lu_event_i) begin
            lu_cnt_d = lu_cnt_q + 1'b1;
        end
        if (mc_event_i) begin
            mc_cnt_d = mc_cnt_q + 1'b1;
        end
    end

    // Counter registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lu_cnt_q <= '0;
            mc_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign load_use_cnt_o = lu_cnt_q;
    assign mc_stall_cnt_o = mc_cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard and stall controller for the RV32IMF five-stage core.
// Resolves load-use dependencies, multi-cycle execute ops and taken-branch
// redirects into stall/flush enables for the IF/ID, ID/EXE and EXE/MEM
// registers. Optional performance counters: define HAZARD_PERF_CNT_EN.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN_CNT = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rs3_id,
    input  logic       rs1_used_id,
    input  logic       rs2_used_id,
    input  logic       rs3_used_id,
    input  logic       rdata1_int_FP_sel_id,
    input  logic       rdata2_int_FP_sel_id,
    input  logic [4:0] rd_exe,
    input  logic       mem_read_exe,
    input  logic       reg_write_exe,
    input  logic       FP_reg_write_exe,
    input  logic       mc_start_exe,
    input  logic       mc_done,
    input  logic       branch_taken_exe,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_exe,
    output logic       flush_id,
    output logic       flush_exe,
    output logic       flush_mem,
    output logic       mc_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [XLEN_CNT-1:0] load_use_cnt,
    output logic [XLEN_CNT-1:0] mc_stall_cnt
`endif
);

    // Counter width must be usable even when the counters are compiled out.
    if (XLEN_CNT < 1) begin : g_bad_cnt_width
        $error("hazard_stall_unit: XLEN_CNT must be at least 1");
    end

    mc_state_e state_q, state_d;
    logic      mc_stall;
    logic      lu;
    logic      lu_int_hit;
    logic      lu_fp_hit;
    logic      lu_eff;

    // Load-use detection, split by register class.
    always_comb begin
        lu_int_hit = 1'b0;
        lu_fp_hit  = 1'b0;
        if (reg_write_exe && (rd_exe != REG_ZERO)) begin
            lu_int_hit = (src_hit(rs1_used_id, rs1_id, rd_exe) && !rdata1_int_FP_sel_id)
                      || (src_hit(rs2_used_id, rs2_id, rd_exe) && !rdata2_int_FP_sel_id);
        end
        // f0 is an ordinary FP register, so no zero-index exclusion here.
        if (FP_reg_write_exe) begin
            lu_fp_hit = (src_hit(rs1_used_id, rs1_id, rd_exe) && rdata1_int_FP_sel_id)
                     || (src_hit(rs2_used_id, rs2_id, rd_exe) && rdata2_int_FP_sel_id)
                     ||  src_hit(rs3_used_id, rs3_id, rd_exe);
        end
        lu = mem_read_exe && (lu_int_hit || lu_fp_hit);
    end

    // Multi-cycle FSM next state and Mealy stall (covers the issue cycle).
    always_comb begin
        state_d  = state_q;
        mc_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mc_start_exe && !mc_done) begin
                    state_d  = BUSY;
                    mc_stall = 1'b1;
                end
            end
            BUSY: begin
                if (mc_done) begin
                    state_d = IDLE;
                end else begin
                    mc_stall = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any multi-cycle operation in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority mux: branch redirect > multi-cycle stall > load-use bubble.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_exe = 1'b0;
        flush_id  = 1'b0;
        flush_exe = 1'b0;
        flush_mem = 1'b0;
        lu_eff    = 1'b0;
        if (reset_n) begin
            if (branch_taken_exe) begin
                flush_id  = 1'b1;
                flush_exe = 1'b1;
            end else if (mc_stall) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_exe = 1'b1;
                flush_mem = 1'b1;
            end else if (lu) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                flush_exe = 1'b1;
                lu_eff    = 1'b1;
            end
        end
    end

    assign mc_busy = reset_n && (state_q == BUSY);

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(
        .XLEN_CNT(XLEN_CNT)
    ) u_perf (
        .clk            (clk),
        .reset_n        (reset_n),
        .lu_event_i     (lu_eff),
        .mc_event_i     (mc_stall),
        .load_use_cnt_o (load_use_cnt),
        .mc_stall_cnt_o (mc_stall_cnt)
    );
`else
    logic unused_lu_eff;
    assign unused_lu_eff = lu_eff;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit. Optional counter
// checks are compiled in with HAZARD_PERF_CNT_EN.
module tb_hazard_stall_unit;

    localparam int unsigned CW = 32;

    // Expected output vector: {stall_if, stall_id, stall_exe, flush_id, flush_exe, flush_mem, mc_busy}
    localparam logic [6:0] NONE = 7'b000_000_0;
    localparam logic [6:0] LU   = 7'b110_010_0;
    localparam logic [6:0] MC   = 7'b111_001_0;
    localparam logic [6:0] MCB  = 7'b111_001_1;
    localparam logic [6:0] BSY  = 7'b000_000_1;
    localparam logic [6:0] BR   = 7'b000_110_0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs1_id, rs2_id, rs3_id;
    logic       rs1_used_id, rs2_used_id, rs3_used_id;
    logic       rdata1_int_FP_sel_id, rdata2_int_FP_sel_id;
    logic [4:0] rd_exe;
    logic       mem_read_exe, reg_write_exe, FP_reg_write_exe;
    logic       mc_start_exe, mc_done, branch_taken_exe;
    logic       stall_if, stall_id, stall_exe;
    logic       flush_id, flush_exe, flush_mem;
    logic       mc_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] load_use_cnt, mc_stall_cnt;
    logic [CW-1:0] exp_lu_cnt, exp_mc_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [6:0]  sb_q[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .XLEN_CNT(CW)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .rs1_id               (rs1_id),
        .rs2_id               (rs2_id),
        .rs3_id               (rs3_id),
        .rs1_used_id          (rs1_used_id),
        .rs2_used_id          (rs2_used_id),
        .rs3_used_id          (rs3_used_id),
        .rdata1_int_FP_sel_id (rdata1_int_FP_sel_id),
        .rdata2_int_FP_sel_id (rdata2_int_FP_sel_id),
        .rd_exe               (rd_exe),
        .mem_read_exe         (mem_read_exe),
        .reg_write_exe        (reg_write_exe),
        .FP_reg_write_exe     (FP_reg_write_exe),
        .mc_start_exe         (mc_start_exe),
        .mc_done              (mc_done),
        .branch_taken_exe     (branch_taken_exe),
        .stall_if             (stall_if),
        .stall_id             (stall_id),
        .stall_exe            (stall_exe),
        .flush_id             (flush_id),
        .flush_exe            (flush_exe),
        .flush_mem            (flush_mem),
        .mc_busy              (mc_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .load_use_cnt         (load_use_cnt),
        .mc_stall_cnt         (mc_stall_cnt)
`endif
    );

    task automatic clr();
        rs1_id = '0; rs2_id = '0; rs3_id = '0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; rs3_used_id = 1'b0;
        rdata1_int_FP_sel_id = 1'b0; rdata2_int_FP_sel_id = 1'b0;
        rd_exe = '0; mem_read_exe = 1'b0; reg_write_exe = 1'b0; FP_reg_write_exe = 1'b0;
        mc_start_exe = 1'b0; mc_done = 1'b0; branch_taken_exe = 1'b0;
    endtask

    // Push expectation, compare at the falling edge, then advance one clock.
    task automatic step(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        logic [6:0] want;
        sb_q.push_back(exp);
        @(negedge clk);
        obs  = {stall_if, stall_id, stall_exe, flush_id, flush_exe, flush_mem, mc_busy};
        want = sb_q.pop_front();
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        assert (load_use_cnt === exp_lu_cnt) else begin
            n_err++;
            $error("FAIL %s_lucnt observed=%0d expected=%0d", tag, load_use_cnt, exp_lu_cnt);
        end
        n_cmp++;
        assert (mc_stall_cnt === exp_mc_cnt) else begin
            n_err++;
            $error("FAIL %s_mccnt observed=%0d expected=%0d", tag, mc_stall_cnt, exp_mc_cnt);
        end
        @(posedge clk);
        if (!reset_n) begin
            exp_lu_cnt = '0;
            exp_mc_cnt = '0;
        end else begin
            if (want[6] && !want[4]) exp_lu_cnt = exp_lu_cnt + 1'b1;
            if (want[4]) exp_mc_cnt = exp_mc_cnt + 1'b1;
        end
`else
        @(posedge clk);
`endif
        #1;
    endtask

    initial begin
`ifdef HAZARD_PERF_CNT_EN
        exp_lu_cnt = '0;
        exp_mc_cnt = '0;
`endif
        // Reset with hazard-provoking inputs: outputs must be forced low.
        clr();
        reset_n = 1'b0;
        rd_exe = 5'd5; mem_read_exe = 1'b1; reg_write_exe = 1'b1;
        rs1_id = 5'd5; rs1_used_id = 1'b1;
        mc_start_exe = 1'b1; branch_taken_exe = 1'b1;
        step("reset_forced0", NONE);
        step("reset_forced1", NONE);
        clr();
        reset_n = 1'b1;
        step("idle_after_reset", NONE);

        // lw x5 in EXE, add x6,x5,x7 in ID.
        rd_exe = 5'd5; mem_read_exe = 1'b1; reg_write_exe = 1'b1;
        rs1_id = 5'd5; rs1_used_id = 1'b1; rs2_id = 5'd7; rs2_used_id = 1'b1;
        step("int_lu", LU);
        clr();
        rs1_id = 5'd5; rs1_used_id = 1'b1; rs2_id = 5'd7; rs2_used_id = 1'b1;
        step("int_lu_release", NONE);

        // rs2 hit only.
        clr();
        rd_exe = 5'd9; mem_read_exe = 1'b1; reg_write_exe = 1'b1;
        rs2_id = 5'd9; rs2_used_id = 1'b1;
        step("int_lu_rs2", LU);

        // Matching index but operand not used.
        rs2_used_id = 1'b0;
        step("unused_operand", NONE);

        // flw f5 in EXE, ID reads integer x5.
        clr();
        rd_exe = 5'd5; mem_read_exe = 1'b1; FP_reg_write_exe = 1'b1;
        rs1_id = 5'd5; rs1_used_id = 1'b1; rdata1_int_FP_sel_id = 1'b0;
        step("class_mismatch", NONE);

        // Same load, fused op reading rs3 = f5.
        rs1_used_id = 1'b0;
        rs3_id = 5'd5; rs3_used_id = 1'b1;
        step("fp_lu_rs3", LU);

        // flw f0, ID reads f0 via rs2.
        clr();
        rd_exe = 5'd0; mem_read_exe = 1'b1; FP_reg_write_exe = 1'b1;
        rs2_id = 5'd0; rs2_used_id = 1'b1; rdata2_int_FP_sel_id = 1'b1;
        step("fp_lu_f0", LU);

        // lw x0 feeding an integer read of x0.
        clr();
        rd_exe = 5'd0; mem_read_exe = 1'b1; reg_write_exe = 1'b1;
        rs1_id = 5'd0; rs1_used_id = 1'b1;
        step("lw_x0", NONE);

        // Integer EXE load must not match an rs3 (always FP) read.
        clr();
        rd_exe = 5'd12; mem_read_exe = 1'b1; reg_write_exe = 1'b1;
        rs3_id = 5'd12; rs3_used_id = 1'b1;
        step("rs3_vs_int", NONE);

        // Branch taken while a load-use is present.
        clr();
        rd_exe = 5'd5; mem_read_exe = 1'b1; reg_write_exe = 1'b1;
        rs1_id = 5'd5; rs1_used_id = 1'b1;
        branch_taken_exe = 1'b1;
        step("branch_over_lu", BR);
        clr();
        step("after_branch", NONE);

        // Divide: start at T, done at T+33.
        mc_start_exe = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (i >= 5 && i < 10) begin
                rd_exe = 5'd3; mem_read_exe = 1'b1; reg_write_exe = 1'b1;
                rs1_id = 5'd3; rs1_used_id = 1'b1;
            end else begin
                rd_exe = '0; mem_read_exe = 1'b0; reg_write_exe = 1'b0;
                rs1_id = '0; rs1_used_id = 1'b0;
            end
            step((i == 0) ? "div_issue" : "div_busy", (i == 0) ? MC : MCB);
        end
        mc_done = 1'b1;
        step("div_done", BSY);
        clr();
        step("div_idle", NONE);

        // Same-cycle start and done.
        mc_start_exe = 1'b1; mc_done = 1'b1;
        step("start_done_same", NONE);
        clr();
        step("start_done_after", NONE);

        // Stray done while idle.
        mc_done = 1'b1;
        step("stray_done", NONE);
        clr();
        step("stray_done_after", NONE);

        // Reset while BUSY.
        mc_start_exe = 1'b1;
        step("rst_busy_issue", MC);
        step("rst_busy_hold", MCB);
        reset_n = 1'b0;
        step("rst_busy_asserted", NONE);
        reset_n = 1'b1;
        clr();
        step("rst_busy_after", NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
